port_data_mux: RTL
==================

# port_data_mux

Downstream companion of the port arbitrator: consumes its grant (enable plus port select) and moves exactly one packet from the granted ingress port to the shared cache write path. Pops the selected port beat by beat, frames the packet with start/end markers, and counts its length. At packet end it returns a one-cycle end-of-packet pulse that releases the arbitrator. Sits between the per-port ingress buffers and the cache write controller.

## Interface
- PORTNUM, 16, number of ingress ports
- DWIDTH, 32, data beat width
- MAXLEN, 256, maximum packet length in beats; LW = $clog2(MAXLEN+1)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  grant enable from arbitrator (o_en)
- i_sel  in  $clog2(PORTNUM)  granted port index (arbitrator o_sel)
- i_data  in  PORTNUM*DWIDTH  per-port beat, port p at [p*DWIDTH +: DWIDTH]
- i_vld / i_sop / i_eop  in  PORTNUM each  per-port beat valid, start, end markers
- o_port_rd  out  PORTNUM  one-hot pop strobe to ingress buffers (combinational)
- i_out_ready  in  1  cache path can take a beat next cycle
- o_data  out  DWIDTH  forwarded beat (registered)
- o_vld / o_sop / o_eop  out  1 each  forwarded beat valid, start, end
- o_pkt_eop  out  1  one-cycle pulse to arbitrator i_eop
- o_len  out  LW  beat count of last packet, valid with o_len_vld
- o_len_vld  out  1  one-cycle pulse
- o_err  out  1  one-cycle pulse: beat dropped, overlength, or abort

## Operation
- States: IDLE, WAIT_SOP, XFER, DONE.
- IDLE: on rising edge of i_en (i_en=1, registered previous i_en=0), latch i_sel into sel_q, clear cnt, go to WAIT_SOP. A level-high i_en without an edge does nothing.
- accept = (state is WAIT_SOP or XFER) & i_vld[sel_q] & i_out_ready; o_port_rd = accept ? (1<<sel_q) : 0.
- WAIT_SOP: accepted beat with i_sop[sel_q]=1 is forwarded with o_sop=1, cnt=1; go to DONE if i_eop also set, else XFER. Accepted beat without sop is popped, not forwarded, and pulses o_err; stay in WAIT_SOP.
- XFER: each accepted beat is forwarded and increments cnt. A beat with i_eop is forwarded with o_eop=1 and moves to DONE. A sop inside XFER is ignored and forwarded as data.
- Overlength: an accepted beat making cnt=MAXLEN without eop is forwarded with forced o_eop=1, o_err pulses, and the FSM moves to DONE.
- DONE: o_pkt_eop=1, o_len_vld=1, o_len=cnt for one cycle, then IDLE.
- Abort: i_en low while in WAIT_SOP or XFER moves the FSM to IDLE. o_err pulses, with no o_pkt_eop and no o_len_vld. A beat accepted in that same cycle is still forwarded.
- cnt saturates at MAXLEN and never wraps.

## Timing
- Reset: state=IDLE, sel_q=0, cnt=0, en_q=0; o_data=0, o_vld/o_sop/o_eop=0, o_pkt_eop=0, o_len=0, o_len_vld=0, o_err=0. o_port_rd=0 combinationally.
- Reset mid-packet: everything returns to reset values immediately. A partial packet already forwarded is not terminated.
- Latency: i_en edge to first possible o_port_rd is 1 cycle. Accepted beat to o_vld is 1 cycle.
- Eop beat accepted at cycle N: o_vld/o_eop at N+1, o_pkt_eop/o_len_vld at N+1 (DONE), IDLE at N+2.
- Throughput: 1 beat/cycle while i_vld[sel_q] & i_out_ready. A single-beat packet occupies 3 cycles from i_en edge to o_pkt_eop.
- The arbitrator drops i_en the cycle after o_pkt_eop, so a new grant is always a fresh rising edge.

## Structure
- Shared package port_pkg holds: the state enum (IDLE, WAIT_SOP, XFER, DONE), the PORTNUM/DWIDTH/MAXLEN defaults, and the LW width function.
- Sub-module port_beat_sel: a combinational PORTNUM:1 mux of {data, vld, sop, eop} indexed by sel_q.
- FSM, counter and output registers live in port_data_mux.

## Test plan
- Grant port 5 with a 4-beat packet (0xA0..0xA3), ready=1 -> o_port_rd=0x0020 for 4 cycles; o_vld beats 0xA0..0xA3 with o_sop on first and o_eop on last; o_pkt_eop and o_len=4 one cycle after the last beat.
- Single-beat packet (sop=eop=1) on port 0 -> one output beat with o_sop=o_eop=1, o_len=1, o_pkt_eop 3 cycles after the i_en edge.
- Port 3 presents 2 non-sop beats, then a 2-beat packet -> two o_err pulses, no forwarded junk, then a clean 2-beat packet with o_len=2.
- i_out_ready toggles 1/0 during a 6-beat packet -> no pop while ready=0; all 6 beats forwarded in order; o_len=6.
- MAXLEN=8, packet of 12 beats without eop -> 8 beats forwarded, 8th with forced o_eop; o_err and o_pkt_eop pulse; o_len=8.
- i_en dropped after 2 beats of a packet -> IDLE, o_err pulse, no o_pkt_eop. Separately, async reset asserted mid-XFER -> all outputs 0 immediately.

Source files
------------

// File: rtl/port_pkg.sv
// Shared types and sizing helpers for the port data mux: FSM state encoding,
// default geometry and the derived select/length widths.
package port_pkg;

    localparam int PORTNUM_DEF = 16;
    localparam int DWIDTH_DEF  = 32;
    localparam int MAXLEN_DEF  = 256;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        XFER     = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Length counter must hold MAXLEN itself, hence the +1.
    function automatic int len_width(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

    function automatic int sel_width(input int portnum);
        return (portnum > 1) ? $clog2(portnum) : 1;
    endfunction

endpackage

// File: rtl/port_data_mux_if.sv
// Grant, per-port ingress and cache-side signals of the port data mux.
// The slave modport is the mux; master is whoever drives grants and beats.
interface port_data_mux_if
    import port_pkg::*;
#(
    parameter int PORTNUM = PORTNUM_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int MAXLEN  = MAXLEN_DEF
);

    localparam int SW = sel_width(PORTNUM);
    localparam int LW = len_width(MAXLEN);

    logic                      i_en;
    logic [SW-1:0]             i_sel;
    logic [PORTNUM*DWIDTH-1:0] i_data;
    logic [PORTNUM-1:0]        i_vld;
    logic [PORTNUM-1:0]        i_sop;
    logic [PORTNUM-1:0]        i_eop;
    logic [PORTNUM-1:0]        o_port_rd;
    logic                      i_out_ready;
    logic [DWIDTH-1:0]         o_data;
    logic                      o_vld;
    logic                      o_sop;
    logic                      o_eop;
    logic                      o_pkt_eop;
    logic [LW-1:0]             o_len;
    logic                      o_len_vld;
    logic                      o_err;

    modport master (
        output i_en, i_sel, i_data, i_vld, i_sop, i_eop, i_out_ready,
        input  o_port_rd, o_data, o_vld, o_sop, o_eop,
               o_pkt_eop, o_len, o_len_vld, o_err
    );

    modport slave (
        input  i_en, i_sel, i_data, i_vld, i_sop, i_eop, i_out_ready,
        output o_port_rd, o_data, o_vld, o_sop, o_eop,
               o_pkt_eop, o_len, o_len_vld, o_err
    );

endinterface

// File: rtl/port_beat_sel.sv
// Combinational PORTNUM:1 selector of the granted port's beat and markers.
module port_beat_sel
    import port_pkg::*;
#(
    parameter int PORTNUM = PORTNUM_DEF,
    parameter int DWIDTH  = DWIDTH_DEF
) (
    input  logic [PORTNUM*DWIDTH-1:0]   data,
    input  logic [PORTNUM-1:0]          vld,
    input  logic [PORTNUM-1:0]          sop,
    input  logic [PORTNUM-1:0]          eop,
    input  logic [sel_width(PORTNUM)-1:0] sel,
    output logic [DWIDTH-1:0]           beat_data,
    output logic                        beat_vld,
    output logic                        beat_sop,
    output logic                        beat_eop
);

    localparam int SW = sel_width(PORTNUM);

    always_comb begin
        beat_data = '0;
        beat_vld  = 1'b0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        for (int p = 0; p < PORTNUM; p++) begin
            if (sel == SW'(p)) begin
                beat_data = data[p*DWIDTH +: DWIDTH];
                beat_vld  = vld[p];
                beat_sop  = sop[p];
                beat_eop  = eop[p];
            end
        end
    end

endmodule

// File: rtl/port_data_mux.sv
// Moves one framed packet from the granted ingress port to the cache write path.
//   state    | meaning
//   IDLE     | waiting for a rising edge of the grant enable
//   WAIT_SOP | popping the granted port until a start-of-packet beat
//   XFER     | forwarding packet body, counting beats
//   DONE     | one cycle reporting end of packet and its length
module port_data_mux
    import port_pkg::*;
#(
    parameter int PORTNUM = PORTNUM_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int MAXLEN  = MAXLEN_DEF
) (
    input logic            i_clk,
    input logic            i_rst_n,
    port_data_mux_if.slave bus
);

    localparam int            SW      = sel_width(PORTNUM);
    localparam int            LW      = len_width(MAXLEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   sel_nxt;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   cnt_nxt;
    logic [LW-1:0]   cnt_inc;
    logic            en_q;

    logic [DWIDTH-1:0] beat_data;
    logic              beat_vld;
    logic              beat_sop;
    logic              beat_eop;
    logic              active;
    logic              accept;

    logic            fwd;
    logic            fwd_sop;
    logic            fwd_eop;
    logic            err;

    logic [DWIDTH-1:0] data_q;
    logic              vld_q;
    logic              sop_q;
    logic              eop_q;
    logic              pkt_eop_q;
    logic [LW-1:0]     len_q;
    logic              len_vld_q;
    logic              err_q;

    port_beat_sel #(
        .PORTNUM (PORTNUM),
        .DWIDTH  (DWIDTH)
    ) u_beat_sel (
        .data      (bus.i_data),
        .vld       (bus.i_vld),
        .sop       (bus.i_sop),
        .eop       (bus.i_eop),
        .sel       (sel_q),
        .beat_data (beat_data),
        .beat_vld  (beat_vld),
        .beat_sop  (beat_sop),
        .beat_eop  (beat_eop)
    );

    assign active        = (state == WAIT_SOP) || (state == XFER);
    assign accept        = active && beat_vld && bus.i_out_ready;
    assign bus.o_port_rd = accept ? (PORTNUM'(1) << sel_q) : '0;

    // First beat always restarts the count; later beats saturate at MAXLEN.
    assign cnt_inc = (state == WAIT_SOP) ? LW'(1)
                   : ((cnt == LEN_MAX) ? cnt : cnt + LW'(1));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt;
        fwd       = 1'b0;
        fwd_sop   = 1'b0;
        fwd_eop   = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_en && !en_q) begin
                    sel_nxt   = bus.i_sel;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (accept) begin
                    if (beat_sop) begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        cnt_nxt = cnt_inc;
                        if (beat_eop) begin
                            fwd_eop   = 1'b1;
                            state_nxt = DONE;
                        end else if (cnt_inc == LEN_MAX) begin
                            fwd_eop   = 1'b1;
                            err       = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = XFER;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            XFER: begin
                if (accept) begin
                    fwd     = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (beat_eop) begin
                        fwd_eop   = 1'b1;
                        state_nxt = DONE;
                    end else if (cnt_inc == LEN_MAX) begin
                        fwd_eop   = 1'b1;
                        err       = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Losing the grant mid-packet wins over any completion this cycle.
        if (active && !bus.i_en) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            cnt   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
            cnt   <= cnt_nxt;
            en_q  <= bus.i_en;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            pkt_eop_q <= 1'b0;
            len_q     <= '0;
            len_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (fwd) begin
                data_q <= beat_data;
            end
            vld_q     <= fwd;
            sop_q     <= fwd_sop;
            eop_q     <= fwd_eop;
            pkt_eop_q <= (state_nxt == DONE);
            len_vld_q <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                len_q <= cnt_nxt;
            end
            err_q     <= err;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_vld     = vld_q;
    assign bus.o_sop     = sop_q;
    assign bus.o_eop     = eop_q;
    assign bus.o_pkt_eop = pkt_eop_q;
    assign bus.o_len     = len_q;
    assign bus.o_len_vld = len_vld_q;
    assign bus.o_err     = err_q;

endmodule
